// File: rtl/video_pipeline_pkg.sv
// ============================================================================
// Module   : video_pipeline_pkg
// Brief    : Shared widths, pattern modes and RGB565 colour-bar constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package video_pipeline_pkg;

  localparam int HACTIVE_BITS   = 11;
  localparam int VACTIVE_BITS   = 11;
  localparam int BITS_PER_PIXEL = 16;

  function automatic int chunkNumBits(input int chunkBits);
    return HACTIVE_BITS - chunkBits;
  endfunction

  function automatic int requestBits(input int chunkBits);
    return VACTIVE_BITS + chunkNumBits(chunkBits);
  endfunction

  typedef enum logic [1:0] {
    PATTERN_SOLID   = 2'd0,
    PATTERN_BARS    = 2'd1,
    PATTERN_CHECKER = 2'd2,
    PATTERN_RAMP    = 2'd3
  } patternMode_t;

  localparam logic [BITS_PER_PIXEL-1:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [BITS_PER_PIXEL-1:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [BITS_PER_PIXEL-1:0] BAR_CYAN    = 16'h07FF;
  localparam logic [BITS_PER_PIXEL-1:0] BAR_GREEN   = 16'h07E0;
  localparam logic [BITS_PER_PIXEL-1:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [BITS_PER_PIXEL-1:0] BAR_RED     = 16'hF800;
  localparam logic [BITS_PER_PIXEL-1:0] BAR_BLUE    = 16'h001F;
  localparam logic [BITS_PER_PIXEL-1:0] BAR_BLACK   = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/video_test_pattern_source_if.sv
// ============================================================================
// Module   : video_test_pattern_source_if
// Brief    : Request/response FIFO connections of a pipeline source element.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface video_test_pattern_source_if #(
  parameter int CHUNK_BITS = 5
);
  localparam int REQUEST_BITS = video_pipeline_pkg::requestBits(CHUNK_BITS);

  logic                                      requestFifoReadEnable;
  logic                                      requestFifoEmpty;
  logic [REQUEST_BITS-1:0]                   requestFifoReadData;
  logic                                      responseFifoWriteEnable;
  logic                                      responseFifoFull;
  logic [video_pipeline_pkg::BITS_PER_PIXEL-1:0] responseFifoWriteData;

  modport master (
    output requestFifoReadEnable,
    input  requestFifoEmpty,
    input  requestFifoReadData,
    output responseFifoWriteEnable,
    input  responseFifoFull,
    output responseFifoWriteData
  );

  modport slave (
    input  requestFifoReadEnable,
    output requestFifoEmpty,
    output requestFifoReadData,
    input  responseFifoWriteEnable,
    output responseFifoFull,
    input  responseFifoWriteData
  );
endinterface

`default_nettype wire

// File: rtl/video_test_pattern_color.sv
// ============================================================================
// Module   : video_test_pattern_color
// Brief    : Combinational test-pattern pixel generator (row, column -> RGB565).
// Revision : 1.0
// ============================================================================
`default_nettype none

module video_test_pattern_color
  import video_pipeline_pkg::*;
(
  input  logic [VACTIVE_BITS-1:0]   row,
  input  logic [HACTIVE_BITS-1:0]   column,
  input  patternMode_t              mode,
  input  logic [BITS_PER_PIXEL-1:0] solidColor,
  output logic [BITS_PER_PIXEL-1:0] pixel
);

  logic w_unusedBits;
  assign w_unusedBits = ^{row[VACTIVE_BITS-1:4], row[2:0], column[1:0]};

  always_comb begin
    pixel = solidColor;
    case (mode)
      PATTERN_SOLID: pixel = solidColor;
      PATTERN_BARS: begin
        case (column[10:8])
          3'd0:    pixel = BAR_WHITE;
          3'd1:    pixel = BAR_YELLOW;
          3'd2:    pixel = BAR_CYAN;
          3'd3:    pixel = BAR_GREEN;
          3'd4:    pixel = BAR_MAGENTA;
          3'd5:    pixel = BAR_RED;
          3'd6:    pixel = BAR_BLUE;
          default: pixel = BAR_BLACK;
        endcase
      end
      PATTERN_CHECKER: pixel = (row[3] ^ column[3]) ? solidColor : '0;
      // Grey ramp: red/blue take the 5 MSBs, green the 6 MSBs of column[7:0]
      PATTERN_RAMP: pixel = {column[7:3], column[7:2], column[7:3]};
      default: pixel = solidColor;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/video_test_pattern_source.sv
// ============================================================================
// Module   : video_test_pattern_source
// Brief    : Pipeline source answering chunk requests with test-pattern pixels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module video_test_pattern_source
  import video_pipeline_pkg::*;
#(
  parameter int CHUNK_BITS = 5
) (
  input  logic                      scalerClock,
  input  logic                      reset,
  input  logic [1:0]                patternMode,
  input  logic [BITS_PER_PIXEL-1:0] solidColor,
  output logic                      busy,
  video_test_pattern_source_if.master fifoBus
);

  localparam int CHUNKNUM_BITS = chunkNumBits(CHUNK_BITS);
  localparam int REQUEST_BITS  = requestBits(CHUNK_BITS);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_READ    = 4'b0010,
    ST_CAPTURE = 4'b0100,
    ST_STREAM  = 4'b1000
  } state_t;

  state_t                    r_state;
  logic                      r_readEnable;
  logic [CHUNK_BITS-1:0]     r_pixelIndex;
  logic [VACTIVE_BITS-1:0]   r_row;
  logic [CHUNKNUM_BITS-1:0]  r_chunk;
  patternMode_t              r_mode;
  logic [BITS_PER_PIXEL-1:0] r_color;
  logic                      w_writeEnable;
  logic [HACTIVE_BITS-1:0]   w_column;

  assign w_writeEnable = (r_state == ST_STREAM) && !fifoBus.responseFifoFull;
  assign w_column      = {r_chunk, r_pixelIndex};

  assign fifoBus.requestFifoReadEnable   = r_readEnable;
  assign fifoBus.responseFifoWriteEnable = w_writeEnable;
  assign busy                            = (r_state != ST_IDLE);

  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_readEnable <= 1'b0;
      r_pixelIndex <= '0;
      r_row        <= '0;
      r_chunk      <= '0;
      r_mode       <= PATTERN_SOLID;
      r_color      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!fifoBus.requestFifoEmpty) begin
            r_readEnable <= 1'b1;
            r_state      <= ST_READ;
          end
        end
        ST_READ: begin
          r_readEnable <= 1'b0;
          r_state      <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Mode and colour are frozen here so a chunk never mixes patterns
          r_row        <= fifoBus.requestFifoReadData[REQUEST_BITS-1 -: VACTIVE_BITS];
          r_chunk      <= fifoBus.requestFifoReadData[CHUNKNUM_BITS-1:0];
          r_mode       <= patternMode_t'(patternMode);
          r_color      <= solidColor;
          r_pixelIndex <= '0;
          r_state      <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_writeEnable) begin
            if (&r_pixelIndex) begin
              r_pixelIndex <= '0;
              r_state      <= ST_IDLE;
            end else begin
              r_pixelIndex <= r_pixelIndex + 1'b1;
            end
          end
        end
        default: begin
          r_readEnable <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  video_test_pattern_color u_color (
    .row        (r_row),
    .column     (w_column),
    .mode       (r_mode),
    .solidColor (r_color),
    .pixel      (fifoBus.responseFifoWriteData)
  );

endmodule

`default_nettype wire

// File: tb/tb_video_test_pattern_source.sv
// ============================================================================
// Module   : tb_video_test_pattern_source
// Brief    : Self-checking bench for video_test_pattern_source.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_video_test_pattern_source;

  localparam int CHUNK_BITS = 5;
  localparam int CHUNK_SIZE = 32;

  logic        scalerClock = 1'b0;
  logic        reset       = 1'b1;
  logic [1:0]  patternMode = 2'd0;
  logic [15:0] solidColor  = 16'h0000;
  logic        busy;

  video_test_pattern_source_if #(.CHUNK_BITS(CHUNK_BITS)) bus();

  video_test_pattern_source #(.CHUNK_BITS(CHUNK_BITS)) dut (
    .scalerClock (scalerClock),
    .reset       (reset),
    .patternMode (patternMode),
    .solidColor  (solidColor),
    .busy        (busy),
    .fifoBus     (bus)
  );

  always #5 scalerClock = ~scalerClock;

  // Request FIFO model: pushes from the stimulus, pops from the monitor
  int          cyc = 0;
  int          pushCount = 0;
  int          popCount = 0;
  logic [16:0] reqMem [64];
  int          reCount = 0;
  int          reCycle [64];
  int          outCount = 0;
  logic [15:0] outData [1024];
  int          outCycle [1024];
  int          fullWrites = 0;

  assign bus.requestFifoEmpty = (pushCount == popCount);

  always @(posedge scalerClock) begin
    cyc <= cyc + 1;
    if (bus.requestFifoReadEnable) begin
      bus.requestFifoReadData <= reqMem[popCount % 64];
      popCount                <= popCount + 1;
      reCycle[reCount % 64]   <= cyc;
      reCount                 <= reCount + 1;
    end
    if (bus.responseFifoWriteEnable) begin
      outData[outCount % 1024]  <= bus.responseFifoWriteData;
      outCycle[outCount % 1024] <= cyc;
      outCount                  <= outCount + 1;
      if (bus.responseFifoFull) fullWrites <= fullWrites + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] refPixel(input int row, input int col, input int mode,
                                           input logic [15:0] color);
    logic [15:0] bars [8];
    int r;
    int g;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (mode)
      0: return color;
      1: return bars[col / 256];
      2: return ((((row / 8) + (col / 8)) % 2) == 1) ? color : 16'h0000;
      default: begin
        r = (col % 256) / 8;
        g = (col % 256) / 4;
        return 16'(r * 2048 + g * 32 + r);
      end
    endcase
  endfunction

  task automatic pushReq(input int row, input int chunk);
    logic [10:0] r;
    logic [5:0]  c;
    r = row[10:0];
    c = chunk[5:0];
    reqMem[pushCount % 64] = {r, c};
    pushCount++;
  endtask

  task automatic waitWrites(input int target, input int budget, input bit randFull, input string tag);
    int n = 0;
    while (outCount < target && n < budget) begin
      @(negedge scalerClock);
      bus.responseFifoFull = randFull ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
    end
    bus.responseFifoFull = 1'b0;
    check({tag, "_done"}, 32'(outCount >= target), 32'd1);
  endtask

  task automatic checkChunk(input int startIdx, input int n, input int row, input int chunk,
                            input int mode, input logic [15:0] color, input string tag);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_px%0d", tag, i), 32'(outData[(startIdx + i) % 1024]),
            32'(refPixel(row, chunk * CHUNK_SIZE + i, mode, color)));
  endtask

  initial begin
    int          releaseCyc;
    int          base;
    int          n;
    int          stallCnt;
    bit          stallChecked;
    int          row;
    int          chunk;
    int          mode;
    logic [15:0] color;
    int          row2;
    int          chunk2;

    bus.responseFifoFull = 1'b0;
    patternMode = 2'd1;
    pushReq(0, 8);

    // Reset held with a pending request: nothing may move
    repeat (5) begin
      @(negedge scalerClock);
      check("reset_readEnable", 32'(bus.requestFifoReadEnable), 32'd0);
      check("reset_writeEnable", 32'(bus.responseFifoWriteEnable), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
    end
    releaseCyc = cyc;
    reset = 1'b0;

    // Bars, chunk 8 -> column 256 -> yellow
    waitWrites(32, 200, 1'b0, "bars8");
    check("first_read_edge", 32'(reCycle[0]), 32'(releaseCyc + 1));
    check("first_write_edge", 32'(outCycle[0]), 32'(releaseCyc + 3));
    check("bars8_first", 32'(outData[0]), 32'h0000_FFE0);
    checkChunk(0, 32, 0, 8, 1, 16'h0000, "bars8");

    pushReq(0, 63);
    waitWrites(64, 200, 1'b0, "bars63");
    check("bars63_last", 32'(outData[63]), 32'h0000_0000);
    checkChunk(32, 32, 0, 63, 1, 16'h0000, "bars63");

    // Checkerboard, row 8 chunk 0
    patternMode = 2'd2;
    solidColor  = 16'hF800;
    pushReq(8, 0);
    waitWrites(96, 200, 1'b0, "checker");
    check("checker_px0", 32'(outData[64]), 32'h0000_F800);
    check("checker_px8", 32'(outData[72]), 32'h0000_0000);
    check("checker_px16", 32'(outData[80]), 32'h0000_F800);
    checkChunk(64, 32, 8, 0, 2, 16'hF800, "checker");

    // Grey ramp, row 0 chunk 1
    patternMode = 2'd3;
    pushReq(0, 1);
    waitWrites(128, 200, 1'b0, "ramp");
    check("ramp_px0", 32'(outData[96]), 32'h0000_2104);
    check("ramp_px31", 32'(outData[127]), 32'h0000_39E7);
    checkChunk(96, 32, 0, 1, 3, 16'hF800, "ramp");

    // Solid with a forced 5-cycle stall after the 10th write, then random full
    patternMode  = 2'd0;
    solidColor   = 16'h1234;
    base         = outCount;
    stallCnt     = 0;
    stallChecked = 1'b0;
    n            = 0;
    pushReq(5, 3);
    while (outCount < base + 32 && n < 1000) begin
      @(negedge scalerClock);
      n++;
      if (outCount - base < 10) begin
        bus.responseFifoFull = 1'b0;
      end else if (stallCnt < 5) begin
        bus.responseFifoFull = 1'b1;
        stallCnt++;
      end else begin
        if (!stallChecked) begin
          check("stall_hold", 32'(outCount), 32'(base + 10));
          stallChecked = 1'b1;
        end
        bus.responseFifoFull = 1'($urandom_range(0, 1));
      end
    end
    bus.responseFifoFull = 1'b0;
    repeat (10) @(negedge scalerClock);
    check("stall_count", 32'(outCount), 32'(base + 32));
    check("stall_no_write_when_full", 32'(fullWrites), 32'd0);
    checkChunk(base, 32, 5, 3, 0, 16'h1234, "stall_solid");

    // Randomised chunks under random backpressure against the model
    for (int k = 0; k < 5; k++) begin
      base  = outCount;
      row   = $urandom_range(0, 2047);
      chunk = $urandom_range(0, 63);
      mode  = (k == 0) ? 2 : $urandom_range(0, 3);
      color = 16'($urandom);
      patternMode = 2'(mode);
      solidColor  = color;
      pushReq(row, chunk);
      waitWrites(base + 32, 1000, 1'b1, $sformatf("rand%0d", k));
      checkChunk(base, 32, row, chunk, mode, color, $sformatf("rand%0d", k));
    end
    repeat (5) @(negedge scalerClock);
    check("rand_no_write_when_full", 32'(fullWrites), 32'd0);

    // Two queued requests; mode switched during the first chunk
    base        = outCount;
    patternMode = 2'd0;
    color       = 16'($urandom);
    solidColor  = color;
    row         = $urandom_range(0, 2047);
    chunk       = $urandom_range(0, 63);
    row2        = $urandom_range(0, 2047);
    chunk2      = $urandom_range(0, 63);
    pushReq(row, chunk);
    pushReq(row2, chunk2);
    waitWrites(base + 1, 200, 1'b0, "queued_first");
    patternMode = 2'd1;
    solidColor  = ~color;
    waitWrites(base + 37, 200, 1'b0, "queued_second");
    // Rises the edge after the last write, seen by the monitor one edge later
    check("second_read_edge", 32'(reCycle[(reCount - 1) % 64]), 32'(outCycle[(base + 31) % 1024] + 2));
    reset = 1'b1;
    #1;
    check("reset_mid_writeEnable", 32'(bus.responseFifoWriteEnable), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge scalerClock);
    check("reset_mid_count", 32'(outCount), 32'(base + 37));
    checkChunk(base, 32, row, chunk, 0, color, "queued_solid");
    checkChunk(base + 32, 5, row2, chunk2, 1, ~color, "queued_bars");
    reset = 1'b0;
    repeat (5) @(negedge scalerClock);
    check("idle_after_reset", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
